// File: rtl/serial_tx.sv
// serial_tx: 8N1 UART transmitter, one byte per new_data strobe, LSB first.
// Latency: tx drops to the start bit on the acceptance edge itself; a frame is 10*CLK_PER_BIT cycles.
// Backpressure: busy (registered) high means new_data is ignored; block holds off acceptance.
// Optional SERIAL_TX_BUF_EN adds a one-entry holding buffer for back-to-back frames.
module serial_tx #(
  parameter int CLK_PER_BIT = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       new_data,
  input  logic       block,
  output logic       busy,
  output logic       tx
);

  localparam int CTR_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             bit_end;
  logic [2:0]       nxt_bit;

`ifdef SERIAL_TX_BUF_EN
  logic [7:0]       buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic             accept;
`else
  logic             accept;
`endif

  assign bit_end = (ctr_q == CTR_LAST);
  assign nxt_bit = bit_q + 3'd1;

`ifdef SERIAL_TX_BUF_EN
  // Buffered build: accept whenever the holding slot is free, in any state.
  assign accept = new_data && !block && !buf_full_q;
`else
  // Base build: only an idle transmitter may take a byte.
  assign accept = new_data && !block && (state_q == IDLE);
`endif

  // Next-state, bit timing and line level for the frame sequencer.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
`ifdef SERIAL_TX_BUF_EN
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        ctr_d = '0;
        if (accept) begin
          shift_d = data;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          ctr_d   = '0;
          bit_d   = 3'd0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          ctr_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = nxt_bit;
            tx_d  = shift_q[nxt_bit];
          end
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          ctr_d   = '0;
          state_d = IDLE;
          tx_d    = 1'b1;
`ifdef SERIAL_TX_BUF_EN
          // Chain straight into the next start bit when a byte is waiting,
          // or when one arrives on this very edge.
          if (buf_full_q) begin
            shift_d    = buf_q;
            buf_full_d = 1'b0;
            state_d    = START;
            tx_d       = 1'b0;
          end else if (accept) begin
            shift_d = data;
            state_d = START;
            tx_d    = 1'b0;
          end
`endif
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
`ifdef SERIAL_TX_BUF_EN
    // Mid-frame arrivals park in the holding slot.
    if (accept && (state_q != IDLE) && !((state_q == STOP) && bit_end)) begin
      buf_d      = data;
      buf_full_d = 1'b1;
    end
    busy_d = buf_full_d | block;
`else
    busy_d = block | (state_d != IDLE);
`endif
  end

  // State register; reset drops the line high at once, abandoning any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SERIAL_TX_BUF_EN
  // Holding buffer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q      <= 8'd0;
      buf_full_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end
`endif

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
